// File: rtl/and16_serial_pkg.sv
// Shared types and helpers for the bit-serial reduction sequencer.
//   op_e       : reduction operator select (AND, OR, XOR, reserved = AND)
//   state_e    : sequencer state
//   early_done : 1 when the running accumulator already decides the result
package and16_serial_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // A zero locks an AND, a one locks an OR; XOR is never decided early.
  function automatic logic early_done(op_e op, logic acc);
    case (op)
      OP_OR:   early_done = acc;
      OP_XOR:  early_done = 1'b0;
      default: early_done = ~acc;  // AND and reserved
    endcase
  endfunction

endpackage

// File: rtl/and16_serial_reducer_reduce_step.sv
// Shared 2-input reduction cell: res_o = op(acc_i, bit_i).
// Ports:
//   op_i  : operator (reserved encoding behaves as AND)
//   acc_i : running accumulator
//   bit_i : next operand bit
//   res_o : combined result
module reduce_step
  import and16_serial_pkg::*;
(
  input  op_e  op_i,
  input  logic acc_i,
  input  logic bit_i,
  output logic res_o
);

  // AND path is a NAND followed by an inverter to map onto the gate library.
  logic nand_w;
  assign nand_w = ~(acc_i & bit_i);

  always_comb begin
    case (op_i)
      OP_OR:   res_o = acc_i | bit_i;
      OP_XOR:  res_o = acc_i ^ bit_i;
      default: res_o = ~nand_w;
    endcase
  end

endmodule

// File: rtl/and16_serial_reducer.sv
// Bit-serial AND/OR/XOR reducer: one shared 2-input cell walks the operand
// from bit 0 upward, one bit per clock, optionally stopping once decided.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o : operand handshake (ready only in IDLE)
//   in_data_i, in_op_i      : operand word and operator, sampled at accept
//   out_valid_o/out_ready_i : result handshake (valid only in DONE)
//   out_data_o              : reduction result
//   out_count_o             : number of operand bits consumed (1..WIDTH)
module and16_serial_reducer
  import and16_serial_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_data_o,
  output logic [CW-1:0]    out_count_o
);

  // Keep the index at least one bit wide so WIDTH==1 still elaborates.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    count_q;
  logic             acc_q;
  logic             acc_d;
  op_e              in_op_w;

  assign in_op_w = op_e'(in_op_i);

  reduce_step u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .bit_i (data_q[idx_q]),
    .res_o (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      data_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q  <= in_data_i;
            op_q    <= in_op_w;
            acc_q   <= in_data_i[0];
            idx_q   <= IW'(1);
            count_q <= CW'(1);
            if (WIDTH == 1 || (EARLY_EXIT && early_done(in_op_w, in_data_i[0])))
              state_q <= DONE;
            else
              state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          // Early test looks at the freshly combined value, not the old acc.
          if (idx_q == IW'(WIDTH - 1) || (EARLY_EXIT && early_done(op_q, acc_d)))
            state_q <= DONE;
          else
            idx_q <= idx_q + IW'(1);
        end
        DONE: begin
          if (out_ready_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register.
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = acc_q;
  assign out_count_o = count_q;

endmodule

// File: tb/tb_and16_serial_reducer.sv
module tb_and16_serial_reducer;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_op = '0;
  logic          out_ready = 1'b0;

  logic          rdy_e, vld_e, dat_e;
  logic [CW-1:0] cnt_e;
  logic          rdy_n, vld_n, dat_n;
  logic [CW-1:0] cnt_n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  and16_serial_reducer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_e),
    .in_data_i(in_data), .in_op_i(in_op),
    .out_valid_o(vld_e), .out_ready_i(out_ready),
    .out_data_o(dat_e), .out_count_o(cnt_e)
  );

  and16_serial_reducer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_ne (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_n),
    .in_data_i(in_data), .in_op_i(in_op),
    .out_valid_o(vld_n), .out_ready_i(out_ready),
    .out_data_o(dat_n), .out_count_o(cnt_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: result from whole-word reduction; bits consumed = position of
  // the first deciding bit (+1) when early exit applies, else all bits.
  function automatic void model(input logic [W-1:0] d, input logic [1:0] op,
                                input bit early, output logic res, output int cnt);
    logic stop_val;
    case (op)
      2'b01:   res = |d;
      2'b10:   res = ^d;
      default: res = &d;
    endcase
    cnt = W;
    if (early && op != 2'b10) begin
      stop_val = (op == 2'b01);
      for (int i = W - 1; i >= 0; i--)
        if (d[i] == stop_val) cnt = i + 1;
    end
  endfunction

  task automatic run_word(input logic [W-1:0] d, input logic [1:0] op);
    logic res_e, res_n;
    int   m_cnt_e, m_cnt_n, e;
    bit   got_e, got_n;
    model(d, op, 1'b1, res_e, m_cnt_e);
    model(d, op, 1'b0, res_n, m_cnt_n);
    check("idle_rdy_e", 32'(rdy_e), 32'd1);
    check("idle_rdy_n", 32'(rdy_n), 32'd1);
    in_valid = 1'b1; in_data = d; in_op = op; out_ready = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept: they must have no effect.
    in_valid = 1'b0; in_data = W'($urandom); in_op = 2'($urandom);
    e = 0; got_e = 1'b0; got_n = 1'b0;
    while (!(got_e && got_n) && e <= W + 4) begin
      if (!got_e && vld_e) begin
        check("data_e", 32'(dat_e), 32'(res_e));
        check("count_e", 32'(cnt_e), 32'(m_cnt_e));
        check("lat_e", 32'(e), 32'(m_cnt_e - 1));
        check("busy_rdy_e", 32'(rdy_e), 32'd0);
        got_e = 1'b1;
      end
      if (!got_n && vld_n) begin
        check("data_n", 32'(dat_n), 32'(res_n));
        check("count_n", 32'(cnt_n), 32'(m_cnt_n));
        check("lat_n", 32'(e), 32'(m_cnt_n - 1));
        got_n = 1'b1;
      end
      if (!(got_e && got_n)) begin
        @(posedge clk); #1;
        e++;
      end
    end
    if (!got_e) check("timeout_e", 32'd0, 32'd1);
    if (!got_n) check("timeout_n", 32'd0, 32'd1);
    $display("txn op=%0d data=%h early:res=%0d cnt=%0d full:res=%0d cnt=%0d",
             op, d, res_e, m_cnt_e, res_n, m_cnt_n);
    @(posedge clk); #1;
  endtask

  task automatic wait_both_idle(input string tag);
    int k = 0;
    while (!(rdy_e && rdy_n) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(rdy_e && rdy_n), 32'd1);
  endtask

  initial begin
    logic [W-1:0] rd;
    int           e;
    bit           stale;

    // Reset values
    #2;
    check("rst_rdy", 32'(rdy_e), 32'd1);
    check("rst_vld", 32'(vld_e), 32'd0);
    check("rst_dat", 32'(dat_e), 32'd0);
    check("rst_cnt", 32'(cnt_e), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_word(16'hFFFF, 2'b00);
    run_word(16'hFFFB, 2'b00);
    run_word(16'h0000, 2'b01);
    run_word(16'h0001, 2'b01);
    run_word(16'h8001, 2'b10);
    run_word(16'h0007, 2'b10);
    run_word(16'hFFFF, 2'b11);
    run_word(16'h7FFF, 2'b11);
    run_word(16'h8000, 2'b01);
    run_word(16'hFFFE, 2'b00);

    // Random cases, biased toward near-all-ones / near-all-zeros words
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: rd = W'($urandom);
        1: rd = ~(W'(1) << $urandom_range(0, W - 1));
        2: rd = W'(1) << $urandom_range(0, W - 1);
        default: rd = $urandom_range(0, 1) ? '1 : '0;
      endcase
      run_word(rd, 2'($urandom_range(0, 3)));
    end

    // Backpressure: result held while a new word waits on in_valid
    in_valid = 1'b1; in_data = 16'hFFFF; in_op = 2'b00; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 16'h0001; in_op = 2'b01;
    e = 0;
    while (!vld_e && e <= W + 4) begin
      @(posedge clk); #1;
      e++;
    end
    check("bp_lat", 32'(e), 32'd15);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_vld", 32'(vld_e), 32'd1);
      check("bp_dat", 32'(dat_e), 32'd1);
      check("bp_cnt", 32'(cnt_e), 32'd16);
      check("bp_rdy", 32'(rdy_e), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_vld", 32'(vld_e), 32'd0);
    check("bp_release_rdy", 32'(rdy_e), 32'd1);
    @(posedge clk); #1;
    check("bp_next_vld", 32'(vld_e), 32'd1);
    check("bp_next_dat", 32'(dat_e), 32'd1);
    check("bp_next_cnt", 32'(cnt_e), 32'd1);
    in_valid = 1'b0;
    $display("txn backpressure hold=5 next op=1 data=0001");
    wait_both_idle("bp_drain");

    // Asynchronous reset in the middle of a scan (idx=7)
    in_valid = 1'b1; in_data = 16'hFFFF; in_op = 2'b00; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_cnt", 32'(cnt_e), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdy", 32'(rdy_e), 32'd1);
    check("arst_vld", 32'(vld_e), 32'd0);
    check("arst_dat", 32'(dat_e), 32'd0);
    check("arst_cnt", 32'(cnt_e), 32'd0);
    check("arst_cnt_n", 32'(cnt_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (vld_e || vld_n || !rdy_e) stale = 1'b1;
    end
    check("post_rst_quiet", 32'(stale), 32'd0);
    $display("txn async reset mid-run idx=7");

    run_word(16'hFFFB, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/and16_serial_reducer.md
Name: and16_serial_reducer

Overview:
Bit-serial reduction sequencer that shares one 2-input gate cell across all bits of a WIDTH-bit word, one bit per clock. It is the area-saving counterpart of the flat 16-input AND tree. It also supports OR and XOR reductions and early termination. Words enter and results leave over valid/ready handshakes, and the block sits between a register-file read port and the flag logic.

Parameters:
WIDTH, 16, operand width in bits (>=1)
EARLY_EXIT, 1, 1 = stop as soon as the AND/OR result is decided; 0 = always consume all WIDTH bits
CW, $clog2(WIDTH+1), width of out_count (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  operand offered
in_ready  output  1  block can accept an operand (high only in IDLE)
in_data  input  WIDTH  operand word
in_op  input  2  00 AND, 01 OR, 10 XOR, 11 reserved (behaves as AND)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  1  reduction result
out_count  output  CW  number of bits consumed (1..WIDTH)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_count=0. Internal shift/index/op registers clear to 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state only. There is no combinational in→out path.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_data and in_op, and set acc<=in_data[0], idx<=1, count<=1.
  - Go to DONE if WIDTH==1 or the early condition holds on acc; otherwise go to RUN.
- RUN:
  - Each edge: acc<=op(acc,data[idx]), count<=count+1.
  - Go to DONE if idx==WIDTH-1 or the early condition holds on the new acc; otherwise idx<=idx+1.
- Early condition (only when EARLY_EXIT=1): AND and acc==0, or OR and acc==1. XOR never exits early.
- DONE:
  - out_valid=1; out_data=acc and out_count=count, both held stable while out_valid is high.
  - On out_ready, go to IDLE and drop out_valid. The earliest next accept is the edge after that, so there is at most one word in flight.
- Latency from accept edge to out_valid high:
  - Full scan: WIDTH-1 edges.
  - Early exit at bit k: k edges, with k=0 meaning the result is visible the cycle after accept.
- Backpressure: DONE holds indefinitely while out_ready=0. in_ready stays 0 in RUN and DONE. in_valid is ignored outside IDLE, and in_data/in_op are sampled only at the accept edge.
- idx width is $clog2(WIDTH), and idx never wraps past WIDTH-1. count width is CW, so WIDTH counts without overflow.
- Reset mid-operation: an asynchronous return to reset values; any partial result is discarded and never emitted.
- The op select is latched at accept, so in_op changes during RUN have no effect.

Decomposition:
- Package and16_serial_pkg holds:
  - op_e enum (OP_AND, OP_OR, OP_XOR, OP_RSVD)
  - state_e enum (IDLE, RUN, DONE)
  - function early_done(op_e, acc)
- Sub-module reduce_step: the combinational shared 2-input cell, out = op(acc, bit). Its AND path is built in NAND form to match the gate-level library. It is instantiated once.

Test Plan:
- AND with in_data=16'hFFFF, EARLY_EXIT=1, out_ready=1 -> out_valid 15 edges after accept, out_data=1, out_count=16.
- AND with in_data=16'hFFFB (bit2=0) -> out_valid 2 edges after accept, out_data=0, out_count=3. With EARLY_EXIT=0 -> 15 edges, out_data=0, out_count=16.
- OR with 16'h0000 -> out_data=0, count=16. OR with 16'h0001 -> out_data=1, count=1, out_valid the cycle after accept.
- XOR with 16'h8001 -> out_data=0, count=16. XOR with 16'h0007 -> out_data=1, count=16.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data -> out_data/out_count stable, in_ready=0, no second accept. After out_ready, the new word is accepted on the following edge.
- Drive rst_n low asynchronously mid-RUN (idx=7) -> outputs return to reset values immediately with no clock. After release, in_ready=1 and no stale out_valid appears.
